display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50000000: minimum clock cycles a shown value stays on the displays before another grant.
REQ-002 SHALL have port clock  in  1: single clock; all state updates on the posedge.
REQ-003 SHALL have port reset  in  1: synchronous, active-low reset.
REQ-004 SHALL have port out_req  in  1: processor OUT-instruction request; level, held until out_ack.
REQ-005 SHALL have port out_value  in  16: unsigned value to show for an OUT request.
REQ-006 SHALL have port in_req  in  1: IN-instruction echo request (switch value); level, held until in_ack.
REQ-007 SHALL have port in_value  in  16: unsigned switch value to show for an IN request.
REQ-008 SHALL have port out_ack  out  1: one-cycle pulse when the OUT value is on the displays.
REQ-009 SHALL have port in_ack  out  1: one-cycle pulse when the IN value is on the displays.
REQ-010 SHALL have port busy  out  1: high in every state except IDLE.
REQ-011 SHALL have port src  out  1: source of the displayed value (1 = OUT, 0 = IN).
REQ-012 SHALL have port overflow  out  1: displayed value exceeded 9999.
REQ-013 SHALL have ports seg3, seg2, seg1, seg0  out  7 each: thousands/hundreds/tens/units digit, active-low, bit order {g,f,e,d,c,b,a}.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE, HOLD.
REQ-015 IDLE: with any request high, SHALL grant one requester and go to LOAD; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: when both requests are high, grant the requester not served last; when only one is high, grant it.
REQ-017 LOAD SHALL capture the granted value into a 16-bit shift register, clear a 20-bit BCD register, and go to SHIFT.
REQ-018 SHIFT SHALL run exactly 16 cycles of double-dabble: add 3 to each BCD nibble >= 5, then shift left one bit from the binary register; afterwards go to DONE.
REQ-019 On the edge entering DONE, seg0..seg3, src and overflow SHALL update together; during DONE the granted ack SHALL be high for exactly one cycle.
REQ-020 Latency: request high in IDLE at cycle 0 -> ack high at cycle 18.
REQ-021 If the BCD tens-of-thousands nibble is nonzero, overflow SHALL be 1 and all four digits SHALL show a dash (7'h3F).
REQ-022 HOLD SHALL count HOLD_CYCLES cycles, then return to IDLE; requests arriving during HOLD wait.
REQ-023 A request dropped after grant SHALL NOT abort the operation: display updates and ack still pulses.
REQ-024 A request dropped before grant SHALL be ignored and not remembered.
REQ-025 Outputs SHALL change only at DONE entry; they SHALL remain stable in every other state.

Reset
REQ-026 reset low at a posedge SHALL force IDLE, all acks 0, busy 0, src 0, overflow 0, segments all-off (7'h7F), and last-served = IN; this applies in any state, including mid-SHIFT.
REQ-027 After reset, the first simultaneous request SHALL grant OUT.

Configuration
REQ-028 Macro DISPLAY_ARBITER_BLANK_EN defined: leading zero digits SHALL be blanked (7'h7F); the units digit is never blanked.
REQ-029 DISPLAY_ARBITER_BLANK_EN undefined: all four digits SHALL always be shown, including leading zeros.

Structure
REQ-030 Shared package display_pkg SHALL hold the FSM state typedef, SEG_BLANK (7'h7F), SEG_DASH (7'h3F), and the width constants (16 binary, 20 BCD).
REQ-031 A single combinational sub-module seg7_decode (4-bit BCD -> 7-bit active-low) SHALL be instantiated four times.

Verification
REQ-032 Reset, then out_req=1 with out_value=1234 -> out_ack at cycle 18; seg3..seg0 = digits 1,2,3,4; src=1; overflow=0.
REQ-033 in_req=1 and out_req=1 in the same cycle after reset (HOLD_CYCLES=4) -> OUT served first; IN acked 18+4+1+18 cycles later.
REQ-034 out_value=12345 -> overflow=1; all four digits = 7'h3F.
REQ-035 in_value=7 -> with the macro: seg3..seg1 = 7'h7F, seg0 = "7"; without the macro: digits 0,0,0,7.
REQ-036 reset asserted mid-SHIFT -> next cycle IDLE; busy=0; segments 7'h7F; no ack pulse.
REQ-037 out_req dropped during SHIFT with out_value=0 -> ack still pulses; seg0 = "0".

Source files
------------

// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter: FSM states, segment codes,
// register widths and the double-dabble step used by the binary-to-BCD converter.
package display_pkg;

  localparam int BIN_W = 16;
  localparam int BCD_W = 20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  // One double-dabble iteration: bias every nibble >= 5 by 3, then shift in bit_in.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic             bit_in);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return (res << 1) | BCD_W'(bit_in);
  endfunction

endpackage

// File: rtl/display_arbiter_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
// Non-decimal codes show nothing.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Digit lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing a four-digit seven-segment display between OUT and IN
// requests. Define DISPLAY_ARBITER_BLANK_EN to blank leading zero digits.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 32'd50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             out_req,
  input  logic [BIN_W-1:0] out_value,
  input  logic             in_req,
  input  logic [BIN_W-1:0] in_value,
  output logic             out_ack,
  output logic             in_ack,
  output logic             busy,
  output logic             src,
  output logic             overflow,
  output logic [6:0]       seg3,
  output logic [6:0]       seg2,
  output logic [6:0]       seg1,
  output logic [6:0]       seg0
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 32'd1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_CYCLES > 32'd1) ? (HOLD_CYCLES - 32'd1) : 32'd0);

  state_e             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [3:0]         shift_cnt_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic               grant_out_q;
  logic               last_out_q;
  logic               out_ack_q;
  logic               in_ack_q;
  logic               busy_q;
  logic               src_q;
  logic               ovf_q;
  logic [6:0]         seg_q [4];

  logic [BIN_W-1:0]   bin_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               grant_out_s;
  logic               ovf_s;
  logic [6:0]         dig_seg_s  [4];
  logic [6:0]         seg_next_s [4];

  // Next shift-register contents and the arbitration decision
  always_comb begin
    bcd_d       = dabble_step(bcd_q, bin_q[BIN_W-1]);
    bin_d       = bin_q << 1;
    grant_out_s = out_req & (~in_req | ~last_out_q);
  end

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd_i (bcd_d[4*g +: 4]),
      .seg_o (dig_seg_s[g])
    );
  end

  // Segment images for the value completing this cycle (valid on the last shift)
  always_comb begin
    ovf_s = (bcd_d[19:16] != 4'd0);
    for (int k = 0; k < 4; k++) begin
      seg_next_s[k] = dig_seg_s[k];
    end
    if (ovf_s) begin
      for (int k = 0; k < 4; k++) begin
        seg_next_s[k] = SEG_DASH;
      end
    end else begin
`ifdef DISPLAY_ARBITER_BLANK_EN
      seg_next_s[3] = (bcd_d[15:12] == 4'd0)  ? SEG_BLANK : dig_seg_s[3];
      seg_next_s[2] = (bcd_d[15:8]  == 8'd0)  ? SEG_BLANK : dig_seg_s[2];
      seg_next_s[1] = (bcd_d[15:4]  == 12'd0) ? SEG_BLANK : dig_seg_s[1];
      seg_next_s[0] = dig_seg_s[0];
`else
      for (int k = 0; k < 4; k++) begin
        seg_next_s[k] = dig_seg_s[k];
      end
`endif
    end
  end

  // Control FSM with registered display and handshake outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= 4'd0;
      hold_cnt_q  <= '0;
      grant_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      out_ack_q   <= 1'b0;
      in_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      src_q       <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        seg_q[k] <= SEG_BLANK;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_req || in_req) begin
            grant_out_q <= grant_out_s;
            last_out_q  <= grant_out_s;
            busy_q      <= 1'b1;
            state_q     <= ST_LOAD;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          bin_q       <= grant_out_q ? out_value : in_value;
          bcd_q       <= '0;
          shift_cnt_q <= 4'd0;
          state_q     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bin_q       <= bin_d;
          bcd_q       <= bcd_d;
          shift_cnt_q <= shift_cnt_q + 4'd1;
          if (shift_cnt_q == 4'd15) begin
            for (int k = 0; k < 4; k++) begin
              seg_q[k] <= seg_next_s[k];
            end
            src_q     <= grant_out_q;
            ovf_q     <= ovf_s;
            out_ack_q <= grant_out_q;
            in_ack_q  <= ~grant_out_q;
            state_q   <= ST_DONE;
          end else begin
            state_q   <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          out_ack_q  <= 1'b0;
          in_ack_q   <= 1'b0;
          hold_cnt_q <= '0;
          state_q    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          out_ack_q <= 1'b0;
          in_ack_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_ack  = out_ack_q;
  assign in_ack   = in_ack_q;
  assign busy     = busy_q;
  assign src      = src_q;
  assign overflow = ovf_q;
  assign seg3     = seg_q[3];
  assign seg2     = seg_q[2];
  assign seg1     = seg_q[1];
  assign seg0     = seg_q[0];

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: vector table, multi-cycle corner sequences
// and randomized transactions checked against a decimal-arithmetic display model.
module tb_display_arbiter;

  localparam int HOLD = 4;
  localparam int ACK_LAT = 18;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        out_req = 1'b0;
  logic [15:0] out_value = 16'd0;
  logic        in_req = 1'b0;
  logic [15:0] in_value = 16'd0;
  logic        out_ack, in_ack, busy, src, overflow;
  logic [6:0]  seg3, seg2, seg1, seg0;

  int checks = 0;
  int errors = 0;
  bit last_in = 1'b1;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    bit o_r;
    int o_v;
    bit i_r;
    int i_v;
    bit exp_src;
  } vec_t;

  vec_t tbl [9];

  display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_req   (out_req),
    .out_value (out_value),
    .in_req    (in_req),
    .in_value  (in_value),
    .out_ack   (out_ack),
    .in_ack    (in_ack),
    .busy      (busy),
    .src       (src),
    .overflow  (overflow),
    .seg3      (seg3),
    .seg2      (seg2),
    .seg1      (seg1),
    .seg0      (seg0)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pattern of digit k (0 = units) for a displayed value
  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 9999) return 7'h3F;
`ifdef DISPLAY_ARBITER_BLANK_EN
    if (k > 0 && v < p) return 7'h7F;
`endif
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int v, input bit exp_src);
    check({tag, "_seg3"}, 32'(seg3), 32'(exp_seg(v, 3)));
    check({tag, "_seg2"}, 32'(seg2), 32'(exp_seg(v, 2)));
    check({tag, "_seg1"}, 32'(seg1), 32'(exp_seg(v, 1)));
    check({tag, "_seg0"}, 32'(seg0), 32'(exp_seg(v, 0)));
    check({tag, "_src"}, 32'(src), 32'(exp_src));
    check({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_acks"}, 32'({out_ack, in_ack}), 32'd0);
    check({tag, "_src"}, 32'(src), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_segs"}, 32'({seg3, seg2, seg1, seg0}), 32'h0FFF_FFFF);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    out_req = 1'b0;
    in_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state(tag);
    reset = 1'b1;
    last_in = 1'b1;
  endtask

  // Called in the ack cycle: display must hold through HOLD and busy drops after HOLD+1 cycles
  task automatic wait_idle(input string tag, input int v, input bit exp_src);
    int n;
    int extra;
    n = 0;
    extra = 0;
    for (int c = 1; c <= HOLD + 10; c++) begin
      @(posedge clock);
      #1;
      if (out_ack || in_ack) extra++;
      if (!busy) begin
        n = c;
        break;
      end
    end
    check({tag, "_idle_lat"}, 32'(n), 32'(HOLD + 1));
    check({tag, "_extra_ack"}, 32'(extra), 32'd0);
    check_disp({tag, "_held"}, v, exp_src);
  endtask

  task automatic do_txn(input bit o_r, input int o_v, input bit i_r, input int i_v,
                        input bit exp_out, input string tag);
    int lat;
    int v;
    bit got_out;
    v = exp_out ? o_v : i_v;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    out_req = o_r; out_value = 16'(o_v);
    in_req = i_r;  in_value = 16'(i_v);
    lat = 0;
    got_out = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) check({tag, "_load_busy"}, 32'(busy), 32'd1);
      if (out_ack || in_ack) begin
        lat = n;
        got_out = out_ack;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(ACK_LAT));
    check({tag, "_which_ack"}, 32'({got_out, in_ack}), 32'({exp_out, !exp_out}));
    check_disp(tag, v, exp_out);
    last_in = !exp_out;
    out_req = 1'b0;
    in_req = 1'b0;
    wait_idle(tag, v, exp_out);
  endtask

  initial begin
    int t_out;
    int t_in;
    int acks;
    int busies;
    int lat;
    bit got_out;

    tbl[0] = '{1'b1, 1234,  1'b0, 0,     1'b1};
    tbl[1] = '{1'b0, 0,     1'b1, 7,     1'b0};
    tbl[2] = '{1'b1, 12345, 1'b0, 0,     1'b1};
    tbl[3] = '{1'b1, 9999,  1'b1, 0,     1'b0};
    tbl[4] = '{1'b1, 10000, 1'b1, 65535, 1'b1};
    tbl[5] = '{1'b0, 0,     1'b1, 100,   1'b0};
    tbl[6] = '{1'b1, 0,     1'b0, 0,     1'b1};
    tbl[7] = '{1'b0, 0,     1'b1, 65535, 1'b0};
    tbl[8] = '{1'b1, 42,    1'b1, 9999,  1'b1};

    do_reset("reset0");
    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].o_r, tbl[i].o_v, tbl[i].i_r, tbl[i].i_v, tbl[i].exp_src,
             $sformatf("vec%0d", i));
    end

    // Simultaneous requests after reset: OUT first, IN after DONE + HOLD + IDLE
    do_reset("reset1");
    out_req = 1'b1; out_value = 16'd4321;
    in_req = 1'b1;  in_value = 16'd56;
    t_out = 0;
    t_in = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clock);
      #1;
      if (out_ack) begin
        t_out = n;
        out_req = 1'b0;
        check_disp("rr_out", 4321, 1'b1);
      end
      if (in_ack) begin
        t_in = n;
        in_req = 1'b0;
        check_disp("rr_in", 56, 1'b0);
        break;
      end
    end
    check("rr_out_lat", 32'(t_out), 32'(ACK_LAT));
    check("rr_in_lat", 32'(t_in), 32'(ACK_LAT + HOLD + 1 + ACK_LAT));
    last_in = 1'b1;
    wait_idle("rr", 56, 1'b0);

    // Reset in the middle of the conversion
    out_req = 1'b1; out_value = 16'd8888;
    repeat (8) @(posedge clock);
    #1;
    check("mid_shift_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    out_req = 1'b0;
    @(posedge clock);
    #1;
    check_reset_state("mid_shift_rst");
    reset = 1'b1;
    last_in = 1'b1;
    acks = 0;
    busies = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clock);
      #1;
      if (out_ack || in_ack) acks++;
      if (busy) busies++;
    end
    check("mid_shift_no_ack", 32'(acks), 32'd0);
    check("mid_shift_no_busy", 32'(busies), 32'd0);
    do_txn(1'b1, 777, 1'b1, 3333, 1'b1, "post_rst_both");

    // Request withdrawn after grant still completes
    out_req = 1'b1; out_value = 16'd0;
    lat = 0;
    got_out = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 5) out_req = 1'b0;
      if (out_ack || in_ack) begin
        lat = n;
        got_out = out_ack;
        break;
      end
    end
    check("drop_lat", 32'(lat), 32'(ACK_LAT));
    check("drop_out_ack", 32'(got_out), 32'd1);
    check_disp("drop", 0, 1'b1);
    last_in = 1'b0;
    wait_idle("drop", 0, 1'b1);

    // Randomized transactions against the round-robin model
    for (int i = 0; i < 30; i++) begin
      int r;
      int ov;
      int iv;
      bit o_r;
      bit i_r;
      r = int'($urandom_range(1, 3));
      o_r = r[0];
      i_r = r[1];
      case ($urandom_range(0, 2))
        0:       begin ov = int'($urandom_range(0, 99));    iv = int'($urandom_range(0, 9)); end
        1:       begin ov = int'($urandom_range(0, 9999));  iv = int'($urandom_range(0, 9999)); end
        default: begin ov = int'($urandom_range(0, 65535)); iv = int'($urandom_range(9990, 65535)); end
      endcase
      do_txn(o_r, ov, i_r, iv, o_r && (!i_r || last_in), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
